// File: rtl/alu_shift_sequencer_pkg.sv
// Shared constants for the ALU control sequencer: ALUop and funct encodings,
// ALU control codes, operation classes and sequencer states.
package alu_shift_sequencer_pkg;

    localparam int CTL_BITS = 6;
    typedef logic [CTL_BITS-1:0] ctl_t;

    localparam logic [4:0] ALUOP_ADD   = 5'd0;
    localparam logic [4:0] ALUOP_SUB   = 5'd1;
    localparam logic [4:0] ALUOP_RTYPE = 5'd2;
    localparam logic [4:0] ALUOP_ADDU  = 5'd3;
    localparam logic [4:0] ALUOP_AND   = 5'd4;
    localparam logic [4:0] ALUOP_OR    = 5'd5;
    localparam logic [4:0] ALUOP_XOR   = 5'd6;
    localparam logic [4:0] ALUOP_SLT   = 5'd7;
    localparam logic [4:0] ALUOP_SLTU  = 5'd8;
    localparam logic [4:0] ALUOP_LUI   = 5'd9;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;
    localparam logic [5:0] F_MAGIC = 6'h30;

    localparam ctl_t CTL_AND   = 6'h00;
    localparam ctl_t CTL_OR    = 6'h01;
    localparam ctl_t CTL_ADD   = 6'h02;
    localparam ctl_t CTL_ADDU  = 6'h03;
    localparam ctl_t CTL_XOR   = 6'h04;
    localparam ctl_t CTL_SUB   = 6'h06;
    localparam ctl_t CTL_SLT   = 6'h07;
    localparam ctl_t CTL_SLTU  = 6'h08;
    localparam ctl_t CTL_LUI   = 6'h09;
    // Each shift kind uses three consecutive codes: 1-step, 2-step, 8-step.
    localparam ctl_t CTL_SLL1  = 6'h0A;
    localparam ctl_t CTL_SLL8  = 6'h0C;
    localparam ctl_t CTL_SRL1  = 6'h0D;
    localparam ctl_t CTL_SRL8  = 6'h0F;
    localparam ctl_t CTL_SRA1  = 6'h10;
    localparam ctl_t CTL_SRA8  = 6'h12;
    localparam ctl_t CTL_MUL   = 6'h13;
    localparam ctl_t CTL_MAGIC = 6'h30;

    typedef enum logic [1:0] {OP_SINGLE, OP_SHIFT, OP_MUL} op_class_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

endpackage

// File: rtl/alu_code_decode.sv
// Combinational map from (ALUop, functionCode) to a base ALU control code and
// operation class. For shifts the base code is the kind's 1-step code.
module alu_code_decode
    import alu_shift_sequencer_pkg::*;
(
    input  logic [4:0] ALUop,
    input  logic [5:0] functionCode,
    output ctl_t       code,
    output op_class_t  op_class
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        code     = CTL_AND;
        op_class = OP_SINGLE;
        unique case (ALUop)
            ALUOP_ADD:  code = CTL_ADD;
            ALUOP_SUB:  code = CTL_SUB;
            ALUOP_ADDU: code = CTL_ADDU;
            ALUOP_AND:  code = CTL_AND;
            ALUOP_OR:   code = CTL_OR;
            ALUOP_XOR:  code = CTL_XOR;
            ALUOP_SLT:  code = CTL_SLT;
            ALUOP_SLTU: code = CTL_SLTU;
            ALUOP_LUI:  code = CTL_LUI;
            ALUOP_RTYPE: begin
                unique case (functionCode)
                    F_ADD:   code = CTL_ADD;
                    F_ADDU:  code = CTL_ADDU;
                    F_SUBU:  code = CTL_SUB;
                    F_AND:   code = CTL_AND;
                    F_OR:    code = CTL_OR;
                    F_XOR:   code = CTL_XOR;
                    F_SLT:   code = CTL_SLT;
                    F_SLTU:  code = CTL_SLTU;
                    F_MFHI,
                    F_MFLO:  code = CTL_AND;
                    F_MAGIC: code = CTL_MAGIC;
                    F_SLL: begin code = CTL_SLL1; op_class = OP_SHIFT; end
                    F_SRL: begin code = CTL_SRL1; op_class = OP_SHIFT; end
                    F_SRA: begin code = CTL_SRA1; op_class = OP_SHIFT; end
                    F_MULTU: begin code = CTL_MUL; op_class = OP_MUL; end
                    default: code = CTL_AND;
                endcase
            end
            default: code = CTL_AND;
        endcase
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// ALU control sequencer: issues one ALU control code per cycle, splitting long
// shifts into 8/2/1-step codes and holding multiply for MUL_CYCLES cycles.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int SHAMT_W    = 5,
    parameter int CTRL_W     = 6,
    parameter int MUL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               flush,
    input  logic [5:0]         functionCode,
    input  logic [4:0]         ALUop,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic [CTRL_W-1:0]  ALUctrl,
    output logic               out_valid,
    output logic               feedback,
    output logic               last,
    output logic               stall
);

    localparam int MW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_t             state, next_state;
    logic [SHAMT_W-1:0] remaining;
    logic [MW-1:0]      mul_left;
    ctl_t               shift_base;

    ctl_t               dec_code;
    op_class_t          dec_class;
    logic               accept, emit;
    logic [SHAMT_W-1:0] amt, rem_after;
    ctl_t               step_off, emit_code;

    alu_code_decode u_decode (
        .ALUop        (ALUop),
        .functionCode (functionCode),
        .code         (dec_code),
        .op_class     (dec_class)
    );

    always_comb begin
        accept     = (state == S_IDLE) && in_valid && !flush;
        emit       = accept || (state != S_IDLE);
        amt        = (state == S_SHIFT) ? remaining : Shamt;
        next_state = S_IDLE;
        emit_code  = CTL_AND;

        // Largest native step that still fits the outstanding amount.
        if (int'(amt) >= 8) begin
            step_off  = ctl_t'(2);
            rem_after = amt - SHAMT_W'(8);
        end else if (int'(amt) >= 2) begin
            step_off  = ctl_t'(1);
            rem_after = amt - SHAMT_W'(2);
        end else begin
            step_off  = ctl_t'(0);
            rem_after = amt - SHAMT_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (dec_class)
                        OP_SINGLE: emit_code = dec_code;
                        OP_SHIFT: begin
                            if (Shamt == '0) begin
                                emit_code = CTL_AND;
                            end else begin
                                emit_code = dec_code + step_off;
                                if (rem_after != '0) next_state = S_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            emit_code = CTL_MUL;
                            if (MUL_CYCLES > 1) next_state = S_MUL;
                        end
                        default: emit_code = CTL_AND;
                    endcase
                end
            end
            S_SHIFT: begin
                emit_code = shift_base + step_off;
                if (rem_after != '0) next_state = S_SHIFT;
            end
            S_MUL: begin
                emit_code = CTL_MUL;
                if (mul_left > MW'(1)) next_state = S_MUL;
            end
            default: next_state = S_IDLE;
        endcase

        if (flush) next_state = S_IDLE;
        stall = (next_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            mul_left   <= '0;
            shift_base <= CTL_AND;
            ALUctrl    <= '0;
            out_valid  <= 1'b0;
            feedback   <= 1'b0;
            last       <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            remaining <= '0;
            mul_left  <= '0;
            ALUctrl   <= '0;
            out_valid <= 1'b0;
            feedback  <= 1'b0;
            last      <= 1'b0;
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments so
            // every read in this block sees the pre-edge value.
            state     <= next_state;
            out_valid <= emit;
            last      <= emit && (next_state == S_IDLE);
            feedback  <= (state == S_SHIFT);
            ALUctrl   <= emit ? CTRL_W'(emit_code) : '0;

            if (next_state == S_SHIFT || state == S_SHIFT) remaining <= rem_after;
            if (accept && dec_class == OP_SHIFT) shift_base <= dec_code;

            if (accept && dec_class == OP_MUL) begin
                mul_left <= MW'(MUL_CYCLES - 1);
            end else if (state == S_MUL) begin
                mul_left <= mul_left - MW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: reset, shifts, multiply, flush and
// single-cycle decode, with hand-computed expected codes.
module tb_alu_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       flush;
    logic [5:0] functionCode;
    logic [4:0] ALUop;
    logic [4:0] Shamt;
    logic [5:0] ALUctrl;
    logic       out_valid;
    logic       feedback;
    logic       last;
    logic       stall;

    int tests = 0;
    int fails = 0;

    logic [5:0] sra_exp   [7] = '{6'h12, 6'h12, 6'h12, 6'h11, 6'h11, 6'h11, 6'h10};
    logic [4:0] sweep_op  [5] = '{5'd9, 5'd2, 5'd2, 5'd2, 5'd1};
    logic [5:0] sweep_fn  [5] = '{6'h00, 6'h30, 6'h2B, 6'h00, 6'h00};
    logic [5:0] sweep_exp [5] = '{6'h09, 6'h30, 6'h08, 6'h00, 6'h06};

    always #5 clk = ~clk;

    alu_shift_sequencer #(
        .SHAMT_W    (5),
        .CTRL_W     (6),
        .MUL_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .flush        (flush),
        .functionCode (functionCode),
        .ALUop        (ALUop),
        .Shamt        (Shamt),
        .ALUctrl      (ALUctrl),
        .out_valid    (out_valid),
        .feedback     (feedback),
        .last         (last),
        .stall        (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [5:0] fn,
                         input logic [4:0] sh);
        in_valid     = v;
        ALUop        = op;
        functionCode = fn;
        Shamt        = sh;
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        tick();
        tick();
        check("rst_ctrl",     ALUctrl,   0);
        check("rst_valid",    out_valid, 0);
        check("rst_feedback", feedback,  0);
        check("rst_last",     last,      0);
        check("rst_stall",    stall,     0);
        rst = 1'b1;

        // Multiply interrupted by reset on its second cycle
        drive(1'b1, 5'd2, 6'h19, 5'd0);
        check("mul_acc_stall", stall, 1);
        tick();
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        check("mul_c1_ctrl",  ALUctrl,   6'h13);
        check("mul_c1_valid", out_valid, 1);
        check("mul_c1_last",  last,      0);
        check("mul_c1_stall", stall,     1);
        tick();
        check("mul_c2_ctrl", ALUctrl, 6'h13);
        rst = 1'b0;
        #1;
        check("midrst_ctrl",  ALUctrl,   0);
        check("midrst_valid", out_valid, 0);
        check("midrst_last",  last,      0);
        check("midrst_stall", stall,     0);
        tick();
        rst = 1'b1;
        drive(1'b1, 5'd0, 6'h00, 5'd0);
        check("postrst_stall", stall, 0);
        tick();
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        check("postrst_add_ctrl",  ALUctrl,   6'h02);
        check("postrst_add_valid", out_valid, 1);
        check("postrst_add_last",  last,      1);
        tick();
        check("postrst_idle_valid", out_valid, 0);

        // SLL by 11: 8 + 2 + 1, Shamt changed after acceptance
        drive(1'b1, 5'd2, 6'h00, 5'd11);
        check("sll_acc_stall", stall, 1);
        tick();
        drive(1'b0, 5'd2, 6'h00, 5'd3);
        check("sll_s1_ctrl",  ALUctrl,  6'h0C);
        check("sll_s1_fb",    feedback, 0);
        check("sll_s1_last",  last,     0);
        check("sll_s1_stall", stall,    1);
        tick();
        check("sll_s2_ctrl",  ALUctrl,  6'h0B);
        check("sll_s2_fb",    feedback, 1);
        check("sll_s2_last",  last,     0);
        check("sll_s2_stall", stall,    0);
        tick();
        check("sll_s3_ctrl",  ALUctrl,   6'h0A);
        check("sll_s3_fb",    feedback,  1);
        check("sll_s3_last",  last,      1);
        check("sll_s3_valid", out_valid, 1);
        tick();
        check("sll_done_valid", out_valid, 0);

        // SRA by 31: three 8-steps, three 2-steps, one 1-step
        drive(1'b1, 5'd2, 6'h03, 5'd31);
        tick();
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("sra_s%0d_ctrl", i + 1), ALUctrl, sra_exp[i]);
            check($sformatf("sra_s%0d_last", i + 1), last, (i == 6) ? 1 : 0);
            check($sformatf("sra_s%0d_valid", i + 1), out_valid, 1);
            tick();
        end
        check("sra_done_valid", out_valid, 0);

        // MULTU followed by ADDU held on the inputs throughout
        drive(1'b1, 5'd2, 6'h19, 5'd0);
        tick();
        drive(1'b1, 5'd2, 6'h21, 5'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mul_b2b_c%0d_ctrl", i + 1), ALUctrl, 6'h13);
            check($sformatf("mul_b2b_c%0d_last", i + 1), last, (i == 3) ? 1 : 0);
            check($sformatf("mul_b2b_c%0d_fb", i + 1), feedback, 0);
            check($sformatf("mul_b2b_c%0d_stall", i + 1), stall, (i < 2) ? 1 : 0);
            tick();
        end
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        check("addu_after_mul_ctrl",  ALUctrl,   6'h03);
        check("addu_after_mul_valid", out_valid, 1);
        check("addu_after_mul_last",  last,      1);
        tick();
        check("addu_once_valid", out_valid, 0);

        // SRL by 5 (2 + 2 + 1), flushed while the second step is presented
        drive(1'b1, 5'd2, 6'h02, 5'd5);
        tick();
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        check("srl_s1_ctrl", ALUctrl, 6'h0E);
        tick();
        check("srl_s2_ctrl", ALUctrl,  6'h0E);
        check("srl_s2_fb",   feedback, 1);
        flush = 1'b1;
        #1;
        check("srl_flush_stall", stall, 0);
        tick();
        flush = 1'b0;
        check("srl_flush_valid", out_valid, 0);
        check("srl_flush_last",  last,      0);
        tick();
        check("srl_no_tail_valid", out_valid, 0);

        // Flush drops an instruction presented in the same cycle
        flush = 1'b1;
        drive(1'b1, 5'd0, 6'h00, 5'd0);
        check("flush_acc_stall", stall, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        check("flush_drop_valid", out_valid, 0);

        // Back-to-back single-cycle sweep
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sweep_op[i], sweep_fn[i], 5'd0);
            check($sformatf("sweep%0d_stall", i), stall, 0);
            tick();
            check($sformatf("sweep%0d_ctrl", i), ALUctrl, sweep_exp[i]);
            check($sformatf("sweep%0d_last", i), last, 1);
            check($sformatf("sweep%0d_valid", i), out_valid, 1);
        end
        drive(1'b0, 5'd0, 6'h00, 5'd0);
        tick();
        check("sweep_done_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
Parametrised successor to the combinational ALU controller. It decodes ALUop, functionCode and Shamt into ALU control codes. Shifts by any amount are split into a sequence of the ALU's native 8/2/1-step shift codes, and multiply is held for a fixed number of cycles. It sits between the decode stage and the ALU, and stalls the pipeline while a multi-cycle sequence runs.

Parameters:
SHAMT_W, 5, width of Shamt; maximum shift is 2^SHAMT_W-1
CTRL_W, 6, width of ALUctrl
MUL_CYCLES, 4, cycles multiply occupies the ALU (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present this cycle
flush  input  1  synchronous abort of any sequence in progress
functionCode  input  6  R-type function field
ALUop  input  5  main-decoder ALU operation
Shamt  input  SHAMT_W  shift amount
ALUctrl  output  CTRL_W  registered ALU control code
out_valid  output  1  ALUctrl is valid this cycle
feedback  output  1  ALU operand A = previous ALU result (not the register file)
last  output  1  final step of the current instruction
stall  output  1  combinational; upstream holds its inputs and in_valid

Behaviour:
- Reset (rst=0, async): state IDLE, remaining=0, mulcnt=0; ALUctrl=0, out_valid=0, feedback=0, last=0, stall=0.
- Latency: outputs are registered. An instruction accepted in cycle N produces its first ALUctrl in cycle N+1.
- Single-cycle code map, ALUop: 0->2, 1->6, 3->3, 4->0, 5->1, 6->4, 7->7, 8->8, 9->9, others->0.
- ALUop=2 (R-type), by funct: 0x20->2, 0x21->3, 0x23->6, 0x24->0, 0x25->1, 0x26->4, 0x2A->7, 0x2B->8, 0x10/0x12->0, 0x30->0x30, others->0.
- Shift step codes (step 8/2/1): SLL funct 0x00 -> C/B/A; SRL 0x02 -> F/E/D; SRA 0x03 -> 12/11/10.
- States: IDLE, SHIFT, MUL.
- IDLE:
  - in_valid with a single-cycle op: ALUctrl=code, out_valid=1, last=1, feedback=0; stay IDLE.
  - Shift with Shamt=0: emit 0x0 as a single-cycle op.
  - Shift with Shamt>0: remaining=Shamt, go to SHIFT.
  - Multiply (funct 0x19): mulcnt=MUL_CYCLES, go to MUL.
  - No in_valid: out_valid=0.
- SHIFT, one step per cycle:
  - step = 8 if remaining>=8, else 2 if remaining>=2, else 1; emit that step's code; remaining -= step.
  - feedback=0 on the first step, 1 on later steps.
  - last=1 when remaining reaches 0, then return to IDLE.
  - Step count = floor(S/8) + floor((S mod 8)/2) + (S mod 2); e.g. S=31 -> 7 steps.
- MUL: emit 0x13 with feedback=0 for MUL_CYCLES cycles; last=1 on the final cycle; then IDLE.
- stall=1 whenever the next state is not IDLE, including the accepting cycle of a multi-step op. in_valid is ignored while stall=1, so the stalled instruction is not accepted twice.
- The next instruction is accepted in the cycle that last=1 is presented (back-to-back, no bubble).
- flush=1 takes priority over everything: next cycle is IDLE with out_valid=0 and stall=0, and a concurrent in_valid is dropped.
- Reset asserted mid-sequence: immediate return to the reset values; no partial-sequence resume.
- Shamt and funct are captured at acceptance; later input changes do not alter a running sequence.

Decomposition:
- Shared package holds:
  - ALUop constants (ALUOP_ADD=0, SUB=1, RTYPE=2, ...).
  - funct constants (F_SLL=0x00, F_SRL=0x02, F_SRA=0x03, F_MULTU=0x19, F_MAGIC=0x30, ...).
  - ALUctrl code constants (CTL_AND=0x0 ... CTL_SRA8=0x12, CTL_MUL=0x13, CTL_MAGIC=0x30).
  - State encoding.
- One sub-module, alu_code_decode: a purely combinational map from (ALUop, functionCode) to base code and op class (single/shift/mul, shift kind). The sequencer instantiates it and owns all state.

Test Plan:
- Reset mid-MUL (cycle 2 of 4), rst low one cycle -> all outputs 0 immediately; IDLE after release; the next ADD (ALUop=0) gives ALUctrl=0x2 one cycle later.
- R-type SLL, Shamt=11 -> ALUctrl C, B, A over 3 cycles; feedback 0,1,1; last on the 3rd; stall high for 2 cycles from acceptance.
- SRA, Shamt=31 -> 12,12,12,11,11,11,10 (7 cycles), last only on the 7th.
- MULTU (funct 0x19), MUL_CYCLES=4, then ADDU (funct 0x21) held on the inputs -> 0x13 x4, then 0x3 in the immediately following cycle with no bubble.
- SRL, Shamt=5, flush on the 2nd step -> out_valid=0 next cycle, stall=0, remaining step not emitted.
- Single-cycle sweep: ALUop 9 -> 0x9, funct 0x30 -> 0x30, funct 0x2B -> 0x8, SLL Shamt=0 -> 0x0; each with last=1 and stall=0.
